// File: rtl/rob_ar_arbiter.sv
// Read-address arbiter in front of the ROB upstream AR port: QoS-first, round-robin tie-break,
// per-requester outstanding-burst limits, requester index prepended to the forwarded AR ID.
module rob_ar_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_W     = $clog2(NUM_REQ),
    parameter int ID_W      = 8,
    parameter int ADDR_W    = 32,
    parameter int MAX_OUTST = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_ar_valid,
    output logic [NUM_REQ-1:0]      req_ar_ready,
    input  logic [NUM_REQ*ID_W-1:0] req_ar_id,
    input  logic [NUM_REQ*ADDR_W-1:0] req_ar_addr,
    input  logic [NUM_REQ*8-1:0]    req_ar_len,
    input  logic [NUM_REQ*3-1:0]    req_ar_size,
    input  logic [NUM_REQ*2-1:0]    req_ar_burst,
    input  logic [NUM_REQ*4-1:0]    req_ar_qos,
    output logic                    out_ar_valid,
    input  logic                    out_ar_ready,
    output logic [IDX_W+ID_W-1:0]   out_ar_id,
    output logic [ADDR_W-1:0]       out_ar_addr,
    output logic [7:0]              out_ar_len,
    output logic [2:0]              out_ar_size,
    output logic [1:0]              out_ar_burst,
    output logic [3:0]              out_ar_qos,
    input  logic                    rsp_valid,
    input  logic                    rsp_ready,
    input  logic                    rsp_last,
    input  logic [IDX_W+ID_W-1:0]   rsp_id,
    output logic [NUM_REQ*8-1:0]    outst_cnt,
    output logic                    err_underflow
);

    logic [7:0]        cnt     [NUM_REQ];
    logic [ID_W-1:0]   id_a    [NUM_REQ];
    logic [ADDR_W-1:0] addr_a  [NUM_REQ];
    logic [7:0]        len_a   [NUM_REQ];
    logic [2:0]        size_a  [NUM_REQ];
    logic [1:0]        burst_a [NUM_REQ];
    logic [3:0]        qos_a   [NUM_REQ];

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] top_qos;
    logic [NUM_REQ-1:0] inc_vec;
    logic [NUM_REQ-1:0] dec_vec;
    logic [3:0]         max_qos;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   scan_idx;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rsp_idx;
    logic               found;
    logic               any_eligible;
    logic               load;
    logic               accept;
    logic               rsp_fire;
    logic               rsp_id_unused;

    assign rsp_idx       = rsp_id[IDX_W+ID_W-1 -: IDX_W];
    assign rsp_id_unused = ^rsp_id[ID_W-1:0];
    assign rsp_fire      = rsp_valid & rsp_ready & rsp_last;
    assign load          = ~out_ar_valid | out_ar_ready;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            id_a[i]    = req_ar_id[i*ID_W +: ID_W];
            addr_a[i]  = req_ar_addr[i*ADDR_W +: ADDR_W];
            len_a[i]   = req_ar_len[i*8 +: 8];
            size_a[i]  = req_ar_size[i*3 +: 3];
            burst_a[i] = req_ar_burst[i*2 +: 2];
            qos_a[i]   = req_ar_qos[i*4 +: 4];
            outst_cnt[i*8 +: 8] = cnt[i];
        end
    end

    // Two passes: find the top QoS level, then round-robin among requesters at that level.
    always_comb begin
        max_qos  = '0;
        grant    = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_ar_valid[i] && (cnt[i] < 8'(MAX_OUTST));
            if (eligible[i] && (qos_a[i] > max_qos))
                max_qos = qos_a[i];
        end
        for (int unsigned i = 0; i < NUM_REQ; i++)
            top_qos[i] = eligible[i] && (qos_a[i] == max_qos);
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = rr_ptr + IDX_W'(k);
            if (!found && top_qos[scan_idx]) begin
                grant = scan_idx;
                found = 1'b1;
            end
        end
        any_eligible = |eligible;
    end

    always_comb begin
        accept       = load & any_eligible & ~rst;
        req_ar_ready = '0;
        if (accept)
            req_ar_ready[grant] = 1'b1;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            inc_vec[i] = accept && (grant == IDX_W'(i));
            dec_vec[i] = rsp_fire && (rsp_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_ar_valid  <= 1'b0;
            out_ar_id     <= '0;
            out_ar_addr   <= '0;
            out_ar_len    <= '0;
            out_ar_size   <= '0;
            out_ar_burst  <= '0;
            out_ar_qos    <= '0;
            rr_ptr        <= '0;
            err_underflow <= 1'b0;
            for (int unsigned i = 0; i < NUM_REQ; i++)
                cnt[i] <= '0;
        end else begin
            if (load) begin
                out_ar_valid <= any_eligible;
                if (any_eligible) begin
                    out_ar_id    <= {grant, id_a[grant]};
                    out_ar_addr  <= addr_a[grant];
                    out_ar_len   <= len_a[grant];
                    out_ar_size  <= size_a[grant];
                    out_ar_burst <= burst_a[grant];
                    out_ar_qos   <= qos_a[grant];
                    rr_ptr       <= grant + IDX_W'(1);
                end
            end
            // A grant and a completion on the same requester cancel out.
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    cnt[i] <= cnt[i] + 8'd1;
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    if (cnt[i] == 8'd0)
                        err_underflow <= 1'b1;
                    else
                        cnt[i] <= cnt[i] - 8'd1;
                end
            end
        end
    end

endmodule

// File: doc/rob_ar_arbiter.md
Name: rob_ar_arbiter

Overview:
- Shares the ROB's single upstream AR port between NUM_REQ read masters.
- Arbitration order: highest QoS first. Ties are broken round-robin.
- Each requester has a limit on outstanding bursts; a completion is taken from the ROB upstream R last beat.
- Prepends the requester index to the AR ID, so R responses are routed back by the upper ID bits.

Parameters:
NUM_REQ, 4, number of requesting masters (power of two, >=2)
IDX_W, $clog2(NUM_REQ), requester index width
ID_W, 8, requester AR ID width
ADDR_W, 32, address width
MAX_OUTST, 8, maximum outstanding bursts per requester (1..255)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_ar_valid  in  NUM_REQ  per-requester AR valid
req_ar_ready  out  NUM_REQ  per-requester AR ready
req_ar_id  in  NUM_REQ*ID_W  packed AR IDs (requester i at [i*ID_W +: ID_W])
req_ar_addr  in  NUM_REQ*ADDR_W  packed addresses
req_ar_len  in  NUM_REQ*8  packed burst lengths (beats-1)
req_ar_size  in  NUM_REQ*3  packed sizes
req_ar_burst  in  NUM_REQ*2  packed burst types
req_ar_qos  in  NUM_REQ*4  packed QoS values
out_ar_valid  out  1  AR valid toward ROB
out_ar_ready  in  1  AR ready from ROB
out_ar_id  out  IDX_W+ID_W  {grant_idx, req_id}
out_ar_addr  out  ADDR_W  forwarded address
out_ar_len  out  8  forwarded length
out_ar_size  out  3  forwarded size
out_ar_burst  out  2  forwarded burst type
out_ar_qos  out  4  forwarded QoS
rsp_valid  in  1  ROB upstream R valid (monitor only)
rsp_ready  in  1  ROB upstream R ready (monitor only)
rsp_last  in  1  ROB upstream R last
rsp_id  in  IDX_W+ID_W  ROB upstream R ID
outst_cnt  out  NUM_REQ*8  packed per-requester outstanding counts
err_underflow  out  1  sticky: a completion arrived for a requester whose count was 0

Behaviour:
- Reset (rst=1 at posedge), all registered state cleared:
  - out_ar_valid=0; all out_ar_* payload fields=0.
  - outst_cnt all 0; rr_ptr=0; err_underflow=0.
  - req_ar_ready is combinational and is 0 while rst=1.
- Reset mid-burst: in-flight AR and all counts are dropped, with no recovery.
- Output register load enable: load = ~out_ar_valid | out_ar_ready.
- Eligibility: requester i is eligible when req_ar_valid[i]=1 and outst_cnt[i] < MAX_OUTST.
- Arbitration is combinational, evaluated only when load=1:
  - Find the maximum QoS among eligible requesters.
  - Among requesters at that QoS, grant the first index found scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- req_ar_ready[i] = load & (grant==i) & any_eligible. It is one-hot or zero.
- Accept (req_ar_valid[g] & req_ar_ready[g]) at posedge:
  - Payload registers on the output; out_ar_valid=1 from the next cycle.
  - outst_cnt[g] += 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Latency: one cycle from request accept to out_ar_valid.
- Throughput: one AR per cycle while out_ar_ready=1.
- Output hold: out_ar_valid=1 & out_ar_ready=0 holds all out_ar_* fields stable; no new grant is made.
- Output drain: out_ar_ready=1 with no eligible requester clears out_ar_valid.
- Completion: rsp_valid & rsp_ready & rsp_last decrements outst_cnt[rsp_id[IDX_W+ID_W-1 -: IDX_W]].
  - Non-last beats are ignored.
- Simultaneous increment and decrement on the same requester in one cycle: count unchanged.
- Decrement when the count is 0: count stays 0 and err_underflow is set (sticky until rst).
- Full requester: at count == MAX_OUTST the requester is ineligible; its req_ar_ready stays 0 until a completion arrives.
- rr_ptr advances only on a grant. QoS does not starve equal-priority peers, but lower-QoS requesters can be starved by design.
- All state lives in one clocked process.

Test Plan:
- Round-robin: requesters 0..3 all valid, QoS=0, out_ar_ready=1 → grant order 0,1,2,3,0. out_ar_id upper bits=0,1,2,3,0 on consecutive cycles.
- QoS priority: req1 QoS=2, req3 QoS=5 → req3 granted first, req1 next cycle. out_ar_qos=5 then 2.
- Backpressure: out_ar_ready=0 for 5 cycles after grant to req2 (addr 0x2000_1000) → out_ar_addr stable at 0x2000_1000, req_ar_ready all 0. Release → accepted, next grant the same cycle.
- Outstanding limit (MAX_OUTST=2): req0 issues 2 ARs → count=2, third request stalls. rsp last beat with rsp_id={2'd0,8'd3} → count=1, stalled request granted the next cycle.
- Same-cycle increment and decrement on req1 → count unchanged. Last beat for req2 at count 0 → count stays 0, err_underflow=1 until rst.
- Reset mid-operation: assert rst with out_ar_valid=1 and counts nonzero → next cycle out_ar_valid=0, all counts 0, rr_ptr=0.
